// File: rtl/rca_serial_pkg.sv
// Shared types and constants for the word-serial ripple-carry adder controller.
// Optional add/subtract mode is enabled with the RCA_SERIAL_ADDSUB_EN macro.
package rca_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

  // The slice index needs at least one bit even when there is a single slice.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/rca_slice4.sv
// Purely combinational 4-bit ripple-carry slice, shared by every cycle of the
// word-serial add.
module rca_slice4
  import rca_serial_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  logic [SLICE_W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < SLICE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[SLICE_W];
  end

endmodule

// File: rtl/rca_word_serial_ctrl.sv
// Word-serial multi-precision adder: one 4-bit slice is stepped over WIDTH/4
// cycles with the inter-slice carry held in a register. RCA_SERIAL_ADDSUB_EN adds a sub port.
module rca_word_serial_ctrl
  import rca_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SERIAL_ADDSUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int NSLICE = slice_count(WIDTH);
  localparam int IDX_W  = idx_width(NSLICE);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
    $error("rca_word_serial_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_valid seen while in_ready
  // is low is simply dropped (nothing is queued).

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_d;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               sub_q;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_co;
  logic               last_slice;
  logic               start_carry;
  logic               start_sub;

`ifdef RCA_SERIAL_ADDSUB_EN
  // Subtraction is a + ~b + 1, so the caller's cin plays no part.
  assign start_sub   = sub;
  assign start_carry = sub ? 1'b1 : cin;
`else
  assign start_sub   = 1'b0;
  assign start_carry = cin;
`endif

  always_comb begin
    a_sl  = '0;
    b_sl  = '0;
    sum_d = sum_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
    if (sub_q) begin
      b_sl = ~b_sl;
    end
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
      end
    end
  end

  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  rca_slice4 u_slice (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      sub_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            sub_q      <= start_sub;
            carry_q    <= start_carry;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_co;
          if (last_slice) begin
            cout_q      <= slice_co;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          // sum/cout are frozen here until the consumer takes them.
          if (out_ready) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rca_word_serial_ctrl.sv
// Bench for rca_word_serial_ctrl: directed cases on a 16-bit instance plus
// randomized back-to-back traffic on 16/4/32-bit instances against a reference model.
module tb_rca_word_serial_ctrl;
  import rca_serial_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;
  int          sel;
  int          total;
  int          bad;
  int          cyc;
  bit          b2b_mode;

  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  cout_v;
  logic [2:0]  busy_v;
  logic [31:0] sum_v [3];
  logic [1:0]  st_v  [3];

  logic        in_ready;
  logic        out_valid;
  logic        cout;
  logic        busy;
  logic [31:0] sum;
  logic [1:0]  st;

  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances (WIDTH 16, 4, 32) ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 16 : ((g == 1) ? 4 : 32);
    logic [W-1:0] s;
    logic [1:0]   stw;
    logic         iv;
    assign iv = in_valid && (sel == g);
    rca_word_serial_ctrl #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (iv),
      .in_ready    (in_ready_v[g]),
      .a           (a[W-1:0]),
      .b           (b[W-1:0]),
      .cin         (cin),
`ifdef RCA_SERIAL_ADDSUB_EN
      .sub         (sub),
`endif
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .sum         (s),
      .cout        (cout_v[g]),
      .busy        (busy_v[g]),
      .dbg_state_o (stw)
    );
    assign sum_v[g] = 32'(s);
    assign st_v[g]  = stw;
  end

  assign in_ready  = in_ready_v[sel];
  assign out_valid = out_valid_v[sel];
  assign cout      = cout_v[sel];
  assign busy      = busy_v[sel];
  assign sum       = sum_v[sel];
  assign st        = st_v[sel];

  function automatic int width_of(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 32);
  endfunction

  // Reference: plain integer arithmetic; cout sits at bit w of the result.
  function automatic logic [63:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv, input logic sv);
    logic [63:0] m;
    logic [63:0] aa;
    logic [63:0] bb;
    m  = (64'd1 << w) - 64'd1;
    aa = 64'(av) & m;
    bb = 64'(bv) & m;
    if (sv) return ((aa - bb) & m) | (64'(aa >= bb) << w);
    return aa + bb + 64'(cv);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  int  last_acc;
  bit  have_last;
  always @(negedge clk) begin
    logic [63:0] e;
    logic [63:0] got;
    int w;
    w = width_of(sel);
    if (!b2b_mode) have_last = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(w, a, b, cin, sub));
        if (b2b_mode && have_last) check("accept_spacing", 64'(cyc - last_acc), 64'(w / 4 + 2));
        last_acc  = cyc;
        have_last = 1'b1;
      end
      if (out_valid && out_ready) begin
        got = (64'(cout) << w) | 64'(sum);
        if (exp_q.size() == 0) begin
          check("unexpected_result", got, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("result", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
    bit done;
    int n;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  // Returns at the negedge where out_valid is first seen; n = edges since accept.
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] held_sum;
    logic        held_cout;
    total = 0; bad = 0; cyc = 0; sel = 0; b2b_mode = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;

    // Basic add with latency and in_ready return.
    send(32'h1234, 32'h0F0F, 1'b0, 1'b0);
    wait_valid(n);
    check("latency", 64'(n), 64'd4);
    check("basic_sum", 64'(sum), 64'h2143);
    check("basic_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Carry rippling across every slice boundary.
    send(32'hFFFF, 32'h0001, 1'b0, 1'b0);
    wait_valid(n);
    check("ripple_sum", 64'(sum), 64'h0000);
    check("ripple_cout", 64'(cout), 64'd1);
    @(posedge clk); #1;
    send(32'hFFFF, 32'h0000, 1'b1, 1'b0);
    wait_valid(n);
    check("cin_ripple_sum", 64'(sum), 64'h0000);
    check("cin_ripple_cout", 64'(cout), 64'd1);
    @(posedge clk); #1;

    // Backpressure in DONE with an ignored in_valid pulse.
    out_ready = 1'b0;
    send(32'hABCD, 32'h1111, 1'b1, 1'b0);
    wait_valid(n);
    held_sum = sum; held_cout = cout;
    check("bp_sum", 64'(held_sum), 64'hBCDF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 1);
      if (i == 1) begin a = 32'h5555; b = 32'h1; end
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum_stable", 64'(sum), 64'(held_sum));
      check("bp_cout_stable", 64'(cout), 64'(held_cout));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_no_extra_valid", 64'(out_valid), 64'd0);
      check("bp_idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of RUN (idx == 2).
    send(32'h4321, 32'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_state", 64'(st), 64'(IDLE));
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(32'h0001, 32'h0001, 1'b0, 1'b0);
    wait_valid(n);
    check("post_abort_sum", 64'(sum), 64'h0002);
    @(posedge clk); #1;

`ifdef RCA_SERIAL_ADDSUB_EN
    send(32'h0005, 32'h0007, 1'b1, 1'b1);
    wait_valid(n);
    check("sub_neg_sum", 64'(sum), 64'hFFFE);
    check("sub_neg_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;
    send(32'h0007, 32'h0005, 1'b0, 1'b1);
    wait_valid(n);
    check("sub_pos_sum", 64'(sum), 64'h0002);
    check("sub_pos_cout", 64'(cout), 64'd1);
    @(posedge clk); #1;
`endif
    drain();

    // Back-to-back random traffic on each width.
    for (int k = 0; k < 3; k++) begin
      sel = k;
      b2b_mode = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
`ifdef RCA_SERIAL_ADDSUB_EN
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
`endif
      end
      drain();
      b2b_mode = 1'b0;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
